// File: rtl/frame_scan_ctrl_pkg.sv
// Shared types for the raster scan controller: FSM state encoding and the
// pixel+tag word carried through the output skid buffer.
package frame_scan_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_HBLANK,
        S_VBLANK,
        S_DRAIN
    } scan_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       sof;
        logic       eol;
        logic       eof;
    } pix_t;

endpackage

// File: rtl/pix_skid2.sv
// Two-entry pixel FIFO; head visible the cycle after push, push/pop may coincide.
// No backpressure of its own: the caller's credit scheme must never push when full.
module pix_skid2
    import frame_scan_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  pix_t       din_i,
    output pix_t       head_o,
    output logic [1:0] count_o,
    output logic       full_o,
    output logic       empty_o
);
    pix_t       mem_q [2];
    logic       wr_q;
    logic       rd_q;
    logic [1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= ~wr_q;
            end
            if (pop_i) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);

    assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));
    assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o));

endmodule

// File: rtl/frame_scan_ctrl.sv
// Raster sequencer: issues (x,y) reads, paces lines/frames, streams RGB out.
// src_rd -> out_valid is 2 cycles; out_ready stalls reads via a 2-credit skid.
module frame_scan_ctrl
    import frame_scan_ctrl_pkg::*;
#(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512,
    parameter int HBLANK = 16,
    parameter int VBLANK = 64,
    parameter int CNT_W  = 11
) (
    input  logic             CAMERA_CLK,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             stop,
    output logic             src_rd,
    output logic [CNT_W-1:0] src_x,
    output logic [CNT_W-1:0] src_y,
    input  logic [7:0]       src_R,
    input  logic [7:0]       src_G,
    input  logic [7:0]       src_B,
    output logic [7:0]       out_R,
    output logic [7:0]       out_G,
    output logic [7:0]       out_B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sof,
    output logic             out_eol,
    output logic             out_eof,
    output logic             busy,
    output logic [15:0]      frame_cnt
);
    localparam logic [CNT_W-1:0] X_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(HEIGHT - 1);
    localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(HBLANK - 1);
    localparam logic [CNT_W-1:0] VB_LAST = CNT_W'(VBLANK - 1);

    scan_state_e      state_q;
    logic [CNT_W-1:0] x_q;
    logic [CNT_W-1:0] y_q;
    logic [CNT_W-1:0] blank_q;
    logic             mode_q;
    logic             stop_pend_q;
    logic             inflight_q;
    logic             sof_q;
    logic             eol_q;
    logic             eof_q;
    logic [15:0]      frame_cnt_q;

    pix_t       push_dat;
    pix_t       head;
    pix_t       shown;
    logic [1:0] occ;
    logic       full;
    logic       empty;
    logic       pop;
    logic [1:0] credit;
    logic       x_last;
    logic       y_last;
    logic       next_frame;

    assign x_last     = (x_q == X_LAST);
    assign y_last     = (y_q == Y_LAST);
    // A stop arriving on the very cycle of the frame decision still counts.
    assign next_frame = mode_q && !stop_pend_q && !stop;

    // The slot freed by this cycle's pop is counted, so a steady out_ready
    // sustains one read per cycle while the skid never exceeds two entries.
    assign pop    = !empty && out_ready;
    assign credit = occ - {1'b0, pop} + {1'b0, inflight_q};
    assign src_rd = (state_q == S_ACTIVE) && !full && (credit < 2'd2);

    assign push_dat = '{r: src_R, g: src_G, b: src_B, sof: sof_q, eol: eol_q, eof: eof_q};

    pix_skid2 u_skid (
        .clk_i   (CAMERA_CLK),
        .rst_i   (rst),
        .push_i  (inflight_q),
        .pop_i   (pop),
        .din_i   (push_dat),
        .head_o  (head),
        .count_o (occ),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge CAMERA_CLK) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            blank_q     <= '0;
            mode_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            inflight_q  <= 1'b0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            inflight_q <= src_rd;
            if (src_rd) begin
                sof_q <= (x_q == '0) && (y_q == '0);
                eol_q <= x_last;
                eof_q <= x_last && y_last;
            end
            if (pop && head.eof) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (stop && state_q != S_IDLE) begin
                stop_pend_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q  <= continuous;
                        x_q     <= '0;
                        y_q     <= '0;
                        state_q <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (src_rd) begin
                        if (!x_last) begin
                            x_q <= x_q + CNT_W'(1);
                        end else begin
                            x_q <= '0;
                            if (!y_last) begin
                                y_q <= y_q + CNT_W'(1);
                                if (HBLANK != 0) begin
                                    blank_q <= '0;
                                    state_q <= S_HBLANK;
                                end
                            end else begin
                                y_q <= '0;
                                if (VBLANK != 0) begin
                                    blank_q <= '0;
                                    state_q <= S_VBLANK;
                                end else if (!next_frame) begin
                                    state_q <= S_DRAIN;
                                end
                            end
                        end
                    end
                end
                S_HBLANK: begin
                    if (blank_q == HB_LAST) begin
                        state_q <= S_ACTIVE;
                    end else begin
                        blank_q <= blank_q + CNT_W'(1);
                    end
                end
                S_VBLANK: begin
                    if (blank_q == VB_LAST) begin
                        state_q <= next_frame ? S_ACTIVE : S_DRAIN;
                    end else begin
                        blank_q <= blank_q + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (empty && !inflight_q) begin
                        stop_pend_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign shown     = empty ? '0 : head;
    assign out_valid = !empty;
    assign out_R     = shown.r;
    assign out_G     = shown.g;
    assign out_B     = shown.b;
    assign out_sof   = shown.sof;
    assign out_eol   = shown.eol;
    assign out_eof   = shown.eof;
    assign src_x     = x_q;
    assign src_y     = y_q;
    assign busy      = (state_q != S_IDLE);
    assign frame_cnt = frame_cnt_q;

endmodule
